// File: rtl/register_bank.sv
// Multi-entry register bank: one write port, two independent registered read ports
// with write-first bypass, per-entry valid bits, sync clear and out-of-range error pulse.
module register_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   input  logic             re_b,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic             rvalid_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             rvalid_b,
   output logic             err
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic [WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic             rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
   logic             err_q, err_d;

   // DEPTH need not be a power of two, so the top of the address space may be unbacked.
   function automatic logic in_range(input logic [AW-1:0] addr);
      return 32'(addr) < DEPTH;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         valid_q <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         valid_q <= '0;
      end else if (we && in_range(waddr)) begin
         mem_q[waddr]   <= wdata;
         valid_q[waddr] <= 1'b1;
      end
   end

   // Port A: clear or bad address yields zero, a same-cycle write to the entry is bypassed.
   always_comb begin
      rdata_a_d  = rdata_a_q;
      rvalid_a_d = rvalid_a_q;
      if (re_a) begin
         if (clr || !in_range(raddr_a)) begin
            rdata_a_d  = '0;
            rvalid_a_d = 1'b0;
         end else if (we && (waddr == raddr_a)) begin
            rdata_a_d  = wdata;
            rvalid_a_d = 1'b1;
         end else begin
            rdata_a_d  = mem_q[raddr_a];
            rvalid_a_d = valid_q[raddr_a];
         end
      end
   end

   always_comb begin
      rdata_b_d  = rdata_b_q;
      rvalid_b_d = rvalid_b_q;
      if (re_b) begin
         if (clr || !in_range(raddr_b)) begin
            rdata_b_d  = '0;
            rvalid_b_d = 1'b0;
         end else if (we && (waddr == raddr_b)) begin
            rdata_b_d  = wdata;
            rvalid_b_d = 1'b1;
         end else begin
            rdata_b_d  = mem_q[raddr_b];
            rvalid_b_d = valid_q[raddr_b];
         end
      end
   end

   // A write dropped by clear is not an error; bad reads still flag.
   always_comb begin
      err_d = (we && !clr && !in_range(waddr)) ||
              (re_a && !in_range(raddr_a)) ||
              (re_b && !in_range(raddr_b));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_q  <= '0;
         rvalid_a_q <= 1'b0;
         rdata_b_q  <= '0;
         rvalid_b_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rdata_a_q  <= rdata_a_d;
         rvalid_a_q <= rvalid_a_d;
         rdata_b_q  <= rdata_b_d;
         rvalid_b_q <= rvalid_b_d;
         err_q      <= err_d;
      end
   end

   assign rdata_a  = rdata_a_q;
   assign rvalid_a = rvalid_a_q;
   assign rdata_b  = rdata_b_q;
   assign rvalid_b = rvalid_b_q;
   assign err      = err_q;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank (WIDTH=8, DEPTH=5): directed vectors, a write-then-read
// memory model checked every cycle, and literal expectations on key steps.
module tb_register_bank;

   localparam int W = 8;
   localparam int D = 5;
   localparam int A = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         clr = 1'b0;
   logic         we = 1'b0;
   logic [A-1:0] waddr = '0;
   logic [W-1:0] wdata = '0;
   logic         re_a = 1'b0;
   logic [A-1:0] raddr_a = '0;
   logic         re_b = 1'b0;
   logic [A-1:0] raddr_b = '0;
   logic [W-1:0] rdata_a, rdata_b;
   logic         rvalid_a, rvalid_b, err;

   int total = 0;
   int bad = 0;
   bit check_en = 1'b0;

   // Model state: memory contents and what the outputs must currently show.
   logic [W-1:0] m_data [D];
   logic         m_valid [D];
   logic [W-1:0] exp_rdata_a = '0, exp_rdata_b = '0;
   logic         exp_rvalid_a = 1'b0, exp_rvalid_b = 1'b0, exp_err = 1'b0;

   register_bank #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re_a     (re_a),
      .raddr_a  (raddr_a),
      .re_b     (re_b),
      .raddr_b  (raddr_b),
      .rdata_a  (rdata_a),
      .rvalid_a (rvalid_a),
      .rdata_b  (rdata_b),
      .rvalid_b (rvalid_b),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("cyc rdata_a", 32'(rdata_a), 32'(exp_rdata_a));
         check("cyc rvalid_a", 32'(rvalid_a), 32'(exp_rvalid_a));
         check("cyc rdata_b", 32'(rdata_b), 32'(exp_rdata_b));
         check("cyc rvalid_b", 32'(rvalid_b), 32'(exp_rvalid_b));
         check("cyc err", 32'(err), 32'(exp_err));
      end
   end

   task automatic model_clear();
      for (int i = 0; i < D; i++) begin
         m_data[i]  = '0;
         m_valid[i] = 1'b0;
      end
      exp_rdata_a  = '0;
      exp_rvalid_a = 1'b0;
      exp_rdata_b  = '0;
      exp_rvalid_b = 1'b0;
      exp_err      = 1'b0;
   endtask

   // Apply one cycle of inputs; the model applies the write (or clear) first and then
   // reads the updated memory, which gives write-first and clear-read behaviour directly.
   task automatic step(input logic w, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic ea, input logic [A-1:0] aa,
                       input logic eb, input logic [A-1:0] ab, input logic c);
      logic [W-1:0] nd [D];
      logic         nv [D];
      logic [W-1:0] na, nb;
      logic         nva, nvb, ne;
      @(negedge clk);
      we = w; waddr = wa; wdata = wd; re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
      clr = c;
      for (int i = 0; i < D; i++) begin
         nd[i] = c ? '0 : m_data[i];
         nv[i] = c ? 1'b0 : m_valid[i];
      end
      if (!c && w && (int'(wa) < D)) begin
         nd[wa] = wd;
         nv[wa] = 1'b1;
      end
      na = exp_rdata_a; nva = exp_rvalid_a;
      nb = exp_rdata_b; nvb = exp_rvalid_b;
      if (ea) begin
         if (int'(aa) < D) begin na = nd[aa]; nva = nv[aa]; end
         else begin na = '0; nva = 1'b0; end
      end
      if (eb) begin
         if (int'(ab) < D) begin nb = nd[ab]; nvb = nv[ab]; end
         else begin nb = '0; nvb = 1'b0; end
      end
      ne = (w && !c && (int'(wa) >= D)) || (ea && (int'(aa) >= D)) || (eb && (int'(ab) >= D));
      @(posedge clk);
      for (int i = 0; i < D; i++) begin
         m_data[i]  = nd[i];
         m_valid[i] = nv[i];
      end
      exp_rdata_a = na; exp_rvalid_a = nva;
      exp_rdata_b = nb; exp_rvalid_b = nvb;
      exp_err = ne;
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; waddr = '0; wdata = '0; re_a = 1'b0; raddr_a = '0;
      re_b = 1'b0; raddr_b = '0; clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      check("reset rdata_a", 32'(rdata_a), 0);
      check("reset rvalid_b", 32'(rvalid_b), 0);
      check("reset err", 32'(err), 0);
      check_en = 1'b1;

      // Inputs driven while in reset must have no effect.
      @(negedge clk);
      we = 1'b1; waddr = 3'd0; wdata = 8'h77; re_a = 1'b1; raddr_a = 3'd7;
      re_b = 1'b1; raddr_b = 3'd0;
      @(posedge clk); #1;
      check("in-reset rdata_b", 32'(rdata_b), 0);
      check("in-reset err", 32'(err), 0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // Read every entry after reset.
      for (int i = 0; i < D; i++) begin
         step(1'b0, 3'd0, 8'h00, 1'b1, A'(i), 1'b1, A'(D - 1 - i), 1'b0);
         check("empty rdata_a", 32'(rdata_a), 0);
         check("empty rvalid_a", 32'(rvalid_a), 0);
         check("empty rvalid_b", 32'(rvalid_b), 0);
         check("empty err", 32'(err), 0);
      end

      // Written entry vs. unwritten entry.
      step(1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd1, 1'b0);
      check("wr2 rdata_a", 32'(rdata_a), 32'hA5);
      check("wr2 rvalid_a", 32'(rvalid_a), 1);
      check("wr2 rdata_b", 32'(rdata_b), 0);
      check("wr2 rvalid_b", 32'(rvalid_b), 0);

      // Write-first bypass on both ports at once.
      step(1'b1, 3'd3, 8'h3C, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
      check("bypass rdata_a", 32'(rdata_a), 32'h3C);
      check("bypass rvalid_a", 32'(rvalid_a), 1);
      check("bypass rdata_b", 32'(rdata_b), 32'h3C);
      check("bypass rvalid_b", 32'(rvalid_b), 1);

      // Out-of-range write and read; port B holds.
      step(1'b1, 3'd6, 8'hEE, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0);
      check("oor rdata_a", 32'(rdata_a), 0);
      check("oor rvalid_a", 32'(rvalid_a), 0);
      check("oor err", 32'(err), 1);
      check("oor hold rdata_b", 32'(rdata_b), 32'h3C);
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      check("oor err clears", 32'(err), 0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0);
      check("oor kept e2", 32'(rdata_a), 32'hA5);
      check("oor kept e3", 32'(rdata_b), 32'h3C);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0);
      check("oor e0 invalid", 32'(rvalid_a), 0);
      check("oor e4 invalid", 32'(rvalid_b), 0);

      // Port-B bad read, disabled bad addresses, bad write under clear.
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0);
      check("oor b err", 32'(err), 1);
      check("oor b rvalid", 32'(rvalid_b), 0);
      step(1'b0, 3'd6, 8'h00, 1'b0, 3'd7, 1'b0, 3'd5, 1'b0);
      check("disabled oor err", 32'(err), 0);
      step(1'b1, 3'd7, 8'h55, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      check("clr oor write err", 32'(err), 0);

      // Fill, then clear with a coincident write and reads.
      for (int i = 0; i < D; i++) step(1'b1, A'(i), 8'(8'h10 + i), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0);
      check("fill e4", 32'(rdata_a), 32'h14);
      check("fill e0", 32'(rdata_b), 32'h10);
      step(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1);
      check("clr read rdata_a", 32'(rdata_a), 0);
      check("clr read rvalid_a", 32'(rvalid_a), 0);
      check("clr read rvalid_b", 32'(rvalid_b), 0);
      for (int i = 0; i < D; i++) begin
         step(1'b0, 3'd0, 8'h00, 1'b1, A'(i), 1'b1, A'(i), 1'b0);
         check("post-clr rdata_a", 32'(rdata_a), 0);
         check("post-clr rvalid_b", 32'(rvalid_b), 0);
      end

      // Hold with re low, then asynchronous reset mid-cycle with a write in flight.
      step(1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
      check("e1 rdata_a", 32'(rdata_a), 32'h11);
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 1'b1, 3'd6, 1'b0);
      check("hold rdata_a", 32'(rdata_a), 32'h11);
      check("hold rvalid_a", 32'(rvalid_a), 1);
      check("hold err", 32'(err), 1);
      @(negedge clk);
      we = 1'b1; waddr = 3'd4; wdata = 8'h99; re_a = 1'b1; raddr_a = 3'd4;
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      check("async rdata_a", 32'(rdata_a), 0);
      check("async rvalid_a", 32'(rvalid_a), 0);
      check("async err", 32'(err), 0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0);
      check("discarded write", 32'(rvalid_a), 0);
      check("reset e1", 32'(rdata_b), 0);
      step(1'b1, 3'd4, 8'h42, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
      check("after reset write", 32'(rdata_a), 32'h42);

      @(negedge clk);
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of each entry and read port.
REQ-002 Parameter DEPTH, default 4, number of entries; legal range 2..256, need not be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH), address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear of all entries and valid bits.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 re_a / re_b  input  1  read enable, port A / port B.
REQ-011 raddr_a / raddr_b  input  AW  read address, port A / port B.
REQ-012 rdata_a / rdata_b  output  WIDTH  registered read data.
REQ-013 rvalid_a / rvalid_b  output  1  registered: the entry read has been written since the last reset or clear.
REQ-014 err  output  1  registered one-cycle pulse on any out-of-range access.

Function
REQ-015 Storage SHALL be DEPTH entries of WIDTH bits, each with one valid bit.
REQ-016 The bank SHALL write wdata to entry waddr and set its valid bit at the clock edge when we=1, clr=0 and waddr<DEPTH.
REQ-017 Read latency SHALL be one cycle: with re_x=1 at edge N, rdata_x/rvalid_x SHALL show entry raddr_x after edge N.
REQ-018 With re_x=0, rdata_x and rvalid_x SHALL hold their previous values.
REQ-019 The read ports SHALL be independent; both may address the same entry in the same cycle.
REQ-020 Write-first bypass: if re_x=1, we=1, clr=0 and raddr_x==waddr (in range), port x SHALL return wdata with rvalid_x=1.
REQ-021 clr=1 SHALL zero all entries and valid bits at the edge, and SHALL take priority over a same-cycle write, which is dropped.
REQ-022 A read coincident with clr=1 SHALL return rdata_x=0 and rvalid_x=0.
REQ-023 An out-of-range write (waddr>=DEPTH) SHALL be ignored, with no entry changed.
REQ-024 An out-of-range read SHALL return rdata_x=0 and rvalid_x=0.
REQ-025 err SHALL be 1 for exactly the cycle after any out-of-range enabled access on any port, and 0 otherwise.
REQ-026 Out-of-range checks SHALL apply only to enabled accesses (we or re_x high).
REQ-027 err SHALL NOT be raised by an out-of-range write coincident with clr=1.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force all entries, valid bits, rdata_a, rdata_b, rvalid_a, rvalid_b and err to 0.
REQ-029 While rst_n=0, all inputs SHALL be ignored.
REQ-030 The first edge after rst_n deasserts SHALL process inputs normally.
REQ-031 Reset asserted mid-operation SHALL discard any write or read in flight.

Verification
REQ-032 Reset, then read all entries: rdata=0 and rvalid=0 on both ports, err=0.
REQ-033 Write 0xA5 to entry 2; next cycle read entry 2 on A and entry 1 on B: A=0xA5/rvalid_a=1, B=0x00/rvalid_b=0.
REQ-034 Same cycle: write 0x3C to entry 3 and read entry 3 on both ports: both return 0x3C with rvalid=1 (bypass).
REQ-035 Fill all entries, then assert clr with a write of 0xFF to entry 0: all reads return 0/rvalid=0 afterwards.
REQ-036 DEPTH=5: write to address 6 and read address 7: no entry changes, read returns 0/rvalid=0, err=1 for one cycle.
REQ-037 Write 0x11 to entry 1, then drop re and change raddr: rdata holds 0x11; assert rst_n=0 between edges: outputs go to 0 at once.
